mem_access_stage: RTL

//  M-stage data-memory access unit. Consumes the EX->M pipeline register outputs (M_*),

---
 rtl/mips32_pkg.sv | 33 +++
 rtl/load_formatter.sv | 40 ++++
 rtl/mem_access_stage.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mips32_pkg.sv
// Shared constants and types for the MIPS32 pipeline slice.
// Holds the op-bit indices, FSM encoding and lane helper.
package mips32_pkg;

  localparam int XLEN       = 32;
  localparam int REG_W      = 5;
  localparam int LOAD_OP_W  = 9;
  localparam int STORE_OP_W = 6;
  localparam int CNT_W      = 16;

  localparam int LOAD_LB  = 0;
  localparam int LOAD_LBU = 1;
  localparam int LOAD_LH  = 2;
  localparam int LOAD_LHU = 3;
  localparam int LOAD_LW  = 4;

  localparam int STORE_SB = 0;
  localparam int STORE_SH = 1;
  localparam int STORE_SW = 2;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mstate_e;

  function automatic logic [1:0] lane_of(
    input logic [1:0] a,
    input bit         big
  );
    return big ? ~a : a;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Selects the addressed byte/half of a load word and extends it.
// Purely combinational; lane order follows BIG_ENDIAN.
module load_formatter
  import mips32_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [XLEN-1:0]      rdata,
  input  logic [1:0]           addr_lo,
  input  logic [LOAD_OP_W-1:0] load_op,
  output logic [XLEN-1:0]      data
);

  logic [1:0]  lane;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    lane = lane_of(addr_lo, BIG_ENDIAN);
    case (lane)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = lane[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    unique case (1'b1)
      load_op[LOAD_LB]:  data = {{24{byte_v[7]}}, byte_v};
      load_op[LOAD_LBU]: data = {24'b0, byte_v};
      load_op[LOAD_LH]:  data = {{16{half_v[15]}}, half_v};
      load_op[LOAD_LHU]: data = {16'b0, half_v};
      default:           data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// M-stage data memory access: req/ack bus master, stall,
// address-error and timeout detection, and the M->W register.
module mem_access_stage
  import mips32_pkg::*;
#(
  parameter int BUS_TIMEOUT = 16,
  parameter bit BIG_ENDIAN  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  M_regwrite,
  input  logic                  M_memtoreg,
  input  logic                  M_memread,
  input  logic                  M_memwrite,
  input  logic [XLEN-1:0]       M_memaddr,
  input  logic [LOAD_OP_W-1:0]  M_load_op,
  input  logic [STORE_OP_W-1:0] M_store_op,
  input  logic [XLEN-1:0]       M_alu_out,
  input  logic [REG_W-1:0]      M_rt_rd,
  output logic                  M_stall,
  output logic                  M_adel,
  output logic                  M_ades,
  output logic                  M_buserr,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [3:0]            dmem_be,
  output logic [XLEN-1:0]       dmem_addr,
  output logic [XLEN-1:0]       dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  W_regwrite,
  output logic [XLEN-1:0]       W_wdata,
  output logic [REG_W-1:0]      W_rt_rd
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(BUS_TIMEOUT - 1);

  mstate_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [3:0]       be_q, be_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic             wreg_q, wreg_d;
  logic [XLEN-1:0]  wdat_q, wdat_d;
  logic [REG_W-1:0] wrd_q, wrd_d;
  logic             adel_q, adel_d;
  logic             ades_q, ades_d;
  logic             berr_q, berr_d;

  logic            access, mis, rsv, to_hit;
  logic            is_b, is_h, is_w;
  logic [1:0]      lane;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c;
  logic [XLEN-1:0] fmt;

  load_formatter #(.BIG_ENDIAN(BIG_ENDIAN)) u_fmt (
    .rdata   (dmem_rdata),
    .addr_lo (M_memaddr[1:0]),
    .load_op (M_load_op),
    .data    (fmt)
  );

  // Reserved op bits and read+write both collapse into the misaligned path.
  always_comb begin
    access = M_memread | M_memwrite;
    rsv    = (|M_load_op[8:5]) | (|M_store_op[5:3])
           | (M_memread & M_memwrite);
    is_b   = M_load_op[LOAD_LB] | M_load_op[LOAD_LBU]
           | M_store_op[STORE_SB];
    is_h   = M_load_op[LOAD_LH] | M_load_op[LOAD_LHU]
           | M_store_op[STORE_SH];
    is_w   = M_load_op[LOAD_LW] | M_store_op[STORE_SW];
    mis    = rsv | (is_h & M_memaddr[0])
           | (is_w & (|M_memaddr[1:0]));
    to_hit = (BUS_TIMEOUT != 0) && (cnt_q == TO_LAST);
    lane   = lane_of(M_memaddr[1:0], BIG_ENDIAN);
  end

  always_comb begin
    be_c    = 4'b0000;
    wdata_c = M_alu_out;
    unique case (1'b1)
      is_b: begin
        be_c    = 4'b0001 << lane;
        wdata_c = {4{M_alu_out[7:0]}};
      end
      is_h: begin
        be_c    = lane[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{M_alu_out[15:0]}};
      end
      is_w: begin
        be_c    = 4'b1111;
        wdata_c = M_alu_out;
      end
      default: begin
        be_c    = 4'b0000;
        wdata_c = M_alu_out;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (access && !mis) state_d = REQ;
      REQ:  if (dmem_ack || to_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    M_stall = 1'b0;
    unique case (state_q)
      IDLE: M_stall = access & ~mis;
      REQ:  M_stall = ~dmem_ack & ~to_hit;
      default: M_stall = 1'b0;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wreg_d  = wreg_q;
    wdat_d  = wdat_q;
    wrd_d   = wrd_q;
    adel_d  = 1'b0;
    ades_d  = 1'b0;
    berr_d  = 1'b0;
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (access && !mis) begin
        req_d   = 1'b1;
        we_d    = M_memwrite;
        be_d    = be_c;
        addr_d  = {M_memaddr[31:2], 2'b00};
        wdata_d = wdata_c;
      end else if (access) begin
        adel_d = M_memread;
        ades_d = ~M_memread;
        wreg_d = 1'b0;
      end else begin
        wreg_d = M_regwrite;
        wdat_d = M_alu_out;
        wrd_d  = M_rt_rd;
      end
    end else if (dmem_ack) begin
      req_d  = 1'b0;
      wreg_d = M_regwrite;
      wdat_d = M_memtoreg ? fmt : M_alu_out;
      wrd_d  = M_rt_rd;
    end else if (to_hit) begin
      req_d  = 1'b0;
      berr_d = 1'b1;
      wreg_d = 1'b0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wreg_q  <= 1'b0;
      wdat_q  <= '0;
      wrd_q   <= '0;
      adel_q  <= 1'b0;
      ades_q  <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wreg_q  <= wreg_d;
      wdat_q  <= wdat_d;
      wrd_q   <= wrd_d;
      adel_q  <= adel_d;
      ades_q  <= ades_d;
      berr_q  <= berr_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_be    = be_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign W_regwrite = wreg_q;
  assign W_wdata    = wdat_q;
  assign W_rt_rd    = wrd_q;
  assign M_adel     = adel_q;
  assign M_ades     = ades_q;
  assign M_buserr   = berr_q;

endmodule
